// File: rtl/elmo_pe_pkg.sv
// Shared definitions for the processing-element sqrt scheduler:
// FSM state encoding and the default watchdog limit.
package elmo_pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 32;

endpackage

// File: rtl/sqrt_sched_f32_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping to 0, reported as one-hot grant plus binary index.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        any   = |valid;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/sqrt_sched_f32.sv
// Shares one iterative squareroot_f32 unit among N requesters: round-robin
// accept, launch by releasing the unit's reset, watchdog, routed response.
module sqrt_sched_f32
    import elmo_pe_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [32*N-1:0] req_data,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    input  logic [N-1:0]    resp_ready,
    output logic [31:0]     resp_data,
    output logic            resp_timeout,
    output logic            busy,
    output logic            sqrt_rst,
    output logic [31:0]     sqrt_a,
    input  logic            sqrt_rdy,
    input  logic [31:0]     sqrt_result,
    output state_t          dbg_state
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on anything but state and valid.

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     sqrt_a_q, sqrt_a_d;
    logic [31:0]     resp_data_q, resp_data_d;
    logic            resp_timeout_q, resp_timeout_d;

    logic [N-1:0]    pick_grant;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [31:0]     pick_data;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_idx == PW'(i)) begin
                pick_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        sqrt_a_d       = sqrt_a_q;
        resp_data_d    = resp_data_q;
        resp_timeout_d = resp_timeout_q;
        req_ready      = '0;
        resp_valid     = '0;
        sqrt_rst       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                req_ready = rst ? '0 : pick_grant;
                if (pick_any) begin
                    sqrt_a_d = pick_data;
                    owner_d  = pick_idx;
                    ptr_d    = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                sqrt_rst = 1'b0;
                cnt_d    = cnt_q + CW'(1);
                // A real rdy in the last allowed cycle beats the watchdog.
                if (sqrt_rdy) begin
                    resp_data_d    = sqrt_result;
                    resp_timeout_d = 1'b0;
                    state_d        = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_data_d    = sqrt_result;
                    resp_timeout_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid[owner_q] = 1'b1;
                if (resp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            sqrt_a_q       <= '0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            sqrt_a_q       <= sqrt_a_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
        end
    end

    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;
    assign sqrt_a       = sqrt_a_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sqrt_sched_f32.sv
// Bench for sqrt_sched_f32 with a latency-programmable root-unit model and a
// round-robin reference model kept as a pending-request set plus pointer.
module tb_sqrt_sched_f32;
    import elmo_pe_pkg::*;

    localparam int N       = 4;
    localparam int TIMEOUT = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_data;
    logic            resp_timeout;
    logic            busy;
    logic            sqrt_rst;
    logic [31:0]     sqrt_a;
    logic            sqrt_rdy;
    logic [31:0]     sqrt_result;
    state_t          dbg_state;

    sqrt_sched_f32 #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .busy         (busy),
        .sqrt_rst     (sqrt_rst),
        .sqrt_a       (sqrt_a),
        .sqrt_rdy     (sqrt_rdy),
        .sqrt_result  (sqrt_result),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- root unit model ----------------
    // rdy first high in RUN cycle mdl_lat (0 = never), sticky until reset.
    int mdl_lat;
    int mcnt;

    function automatic logic [31:0] root_f(input logic [31:0] a);
        case (a)
            32'h40000000: root_f = 32'h3fb504f3;
            32'h40400000: root_f = 32'h3fddb3d7;
            32'h3f800000: root_f = 32'h3f800000;
            32'h3fc00000: root_f = 32'h3f9cc471;
            default:      root_f = (a >> 1) + 32'h1fc00000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (sqrt_rst) mcnt <= 0;
        else          mcnt <= mcnt + 1;
    end
    assign sqrt_rdy    = !sqrt_rst && (mdl_lat != 0) && (mcnt + 1 >= mdl_lat);
    assign sqrt_result = root_f(sqrt_a);

    // ---------------- scoreboard ----------------
    int tests;
    int fails;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [N-1:0] pend;
    logic [31:0]  pdata [N];
    int           ptr_m;

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = pdata[i];
    endtask

    // ---------------- driver ----------------
    // Called at a negedge while the DUT is idle with at least one pending request.
    task automatic do_txn(input int lat, input int hold, input int abort_at);
        int          win;
        int          exp_lat;
        bit          exp_to;
        bit          seen;
        logic [31:0] a;
        logic [31:0] exp_d;
        logic [31:0] got_d;
        logic [N-1:0] onehot;
        win = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (win < 0 && pend[j]) win = j;
        end
        if (win < 0) begin
            check("no_pending_request", 0, 1);
            return;
        end
        mdl_lat = lat;
        drive_reqs();
        #1;
        onehot = '0;
        onehot[win] = 1'b1;
        check("grant", req_ready, onehot);
        check("idle_busy", busy, 0);
        a      = pdata[win];
        exp_d  = root_f(a);
        exp_to = (lat == 0) || (lat > TIMEOUT);
        exp_lat = exp_to ? TIMEOUT : lat;
        exp_q.push_back(exp_d);
        @(posedge clk);
        @(negedge clk);
        pend[win] = 1'b0;
        ptr_m     = (win + 1) % N;
        drive_reqs();
        check("load_sqrt_rst", sqrt_rst, 1);
        check("load_sqrt_a", sqrt_a, a);
        check("load_state", dbg_state, ST_LOAD);
        check("load_req_ready", req_ready, 0);
        seen = 1'b0;
        for (int m = 1; m <= TIMEOUT + 4 && !seen; m++) begin
            @(posedge clk);
            @(negedge clk);
            if (m == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_busy", busy, 0);
                check("rst_resp_valid", resp_valid, 0);
                check("rst_req_ready", req_ready, 0);
                check("rst_sqrt_rst", sqrt_rst, 1);
                check("rst_sqrt_a", sqrt_a, 0);
                check("rst_resp_data", resp_data, 0);
                check("rst_resp_timeout", resp_timeout, 0);
                rst = 1'b0;
                ptr_m = 0;
                void'(exp_q.pop_back());
                return;
            end
            if (resp_valid != '0) begin
                seen = 1'b1;
                check("latency", m, exp_lat + 1);
            end else if (m <= exp_lat) begin
                check("run_sqrt_rst", sqrt_rst, 0);
            end
        end
        if (!seen) begin
            check("resp_valid_timeout", 0, 1);
            void'(exp_q.pop_front());
            return;
        end
        check("resp_route", resp_valid, onehot);
        check("resp_data", resp_data, exp_q.pop_front());
        check("resp_timeout", resp_timeout, exp_to);
        check("done_sqrt_rst", sqrt_rst, 1);
        got_d = resp_data;
        // Non-owners say ready during the hold; the DUT must ignore them.
        resp_ready = ~onehot;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_resp_valid", resp_valid, onehot);
            check("hold_resp_data", resp_data, got_d);
            check("hold_resp_timeout", resp_timeout, exp_to);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = '1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = '0;
        check("post_hs_busy", busy, 0);
        check("post_hs_resp_valid", resp_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat_sel;
        int lat;
        tests = 0;
        fails = 0;
        ptr_m = 0;
        mdl_lat = 0;
        rst = 1'b1;
        resp_ready = '0;
        pend = '1;
        for (int i = 0; i < N; i++) pdata[i] = 32'h40000000 + i;
        drive_reqs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_sqrt_rst", sqrt_rst, 1);
        check("reset_sqrt_a", sqrt_a, 0);
        check("reset_resp_data", resp_data, 0);
        check("reset_resp_timeout", resp_timeout, 0);
        pend = '0;
        drive_reqs();
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", req_ready, 0);

        // Single request, latency 13.
        pend[0] = 1'b1;
        pdata[0] = 32'h40000000;
        do_txn(13, 0, 0);

        // Bring the pointer back to 0, then all four at once.
        pend[3] = 1'b1;
        pdata[3] = 32'h3f000000;
        do_txn(4, 0, 0);
        pend = '1;
        pdata[0] = 32'h40000000;
        pdata[1] = 32'h40400000;
        pdata[2] = 32'h3f800000;
        pdata[3] = 32'h3fc00000;
        for (int i = 0; i < N; i++) do_txn($urandom_range(2, 24), 0, 0);

        // Pointer wrap, with back-pressure while requester 2 waits.
        pend[0] = 1'b1;
        pend[2] = 1'b1;
        do_txn(6, 5, 0);
        do_txn(2, 0, 0);

        // Watchdog, then a normal completion.
        pend[1] = 1'b1;
        pdata[1] = 32'h41000000;
        do_txn(0, 0, 0);
        pend[1] = 1'b1;
        do_txn(9, 0, 0);

        // rdy at the watchdog boundary.
        pend[2] = 1'b1;
        pdata[2] = 32'h40400000;
        do_txn(TIMEOUT, 0, 0);

        // Reset in RUN cycle 5; next grant must go to requester 0.
        pend = '1;
        do_txn(20, 0, 5);
        pend = '1;
        do_txn(3, 0, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end
            end
            if (pend == '0) begin
                pend[$urandom_range(0, N - 1)] = 1'b1;
            end
            lat_sel = $urandom_range(0, 9);
            if (lat_sel == 0)      lat = 0;
            else if (lat_sel == 1) lat = TIMEOUT;
            else if (lat_sel == 2) lat = TIMEOUT + 3;
            else                   lat = $urandom_range(2, 24);
            do_txn(lat, $urandom_range(0, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/sqrt_sched_f32.md
# sqrt_sched_f32

Sequencer and round-robin arbiter that shares one iterative `squareroot_f32` unit among N processing-element requesters. It accepts one request at a time through a valid/ready handshake and starts the root unit by releasing its reset. It then waits for `rdy`, which arrives after a variable latency of 2–24 cycles, and returns the result to the owning requester. A watchdog bounds a hung computation.

## Interface
- `N`, default 4: number of requesters (2–8).
- `TIMEOUT`, default 32: maximum RUN cycles before forced completion (≥ 4).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req_valid`  in  N: per-requester request valid.
- `req_data`  in  32·N: flattened f32 operands; requester i is at bits [32i+31:32i].
- `req_ready`  out  N: one-hot grant/accept.
- `resp_valid`  out  N: one-hot result valid, routed to the owner.
- `resp_ready`  in  N: per-requester result accept.
- `resp_data`  out  32: f32 root, shared by all requesters.
- `resp_timeout`  out  1: result was forced by the watchdog.
- `busy`  out  1: high in any state other than IDLE.
- `sqrt_rst`  out  1: drives the root unit's `rst`.
- `sqrt_a`  out  32: drives the root unit's `a`.
- `sqrt_rdy`  in  1: from the root unit's `rdy`.
- `sqrt_result`  in  32: from the root unit's `sqrt`.

## Operation
- **States:** IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `req_ready` is the round-robin winner among `req_valid`; it is combinational and gated by the state.
  - The search starts at pointer `ptr` and wraps upward (ptr, ptr+1, …, N-1, 0, …).
  - On `req_valid[i] & req_ready[i]`: register `sqrt_a ← req_data[i]`, `owner ← i`, `ptr ← (i+1) mod N`, and go to LOAD.
  - With no valid requests, stay in IDLE.
- **LOAD:** one cycle. `sqrt_rst` = 1 with the new `sqrt_a` stable. Clear the watchdog counter and go to RUN.
- **RUN**
  - `sqrt_rst` = 0. The counter increments every cycle.
  - If `sqrt_rdy`: capture `resp_data ← sqrt_result`, set `resp_timeout` = 0, go to DONE.
  - Else if the counter = TIMEOUT-1: capture `resp_data ← sqrt_result`, set `resp_timeout` = 1, go to DONE.
  - If `sqrt_rdy` and the timeout occur in the same cycle, `rdy` wins and `resp_timeout` = 0.
- **DONE**
  - `resp_valid[owner]` = 1. `resp_data` and `resp_timeout` are held stable.
  - On `resp_ready[owner]`: go to IDLE. `resp_ready` of non-owners is ignored.
- `sqrt_rst` = 1 in IDLE, LOAD and DONE, so the root unit is idle and its `rdy` is cleared before every launch.
- `sqrt_a` holds its last value until the next accept.
- A requester may drop `req_valid` before its handshake with no side effects. `req_data` is sampled only at the accept edge.
- Signed, zero, Inf and NaN inputs pass through unchanged. Their handling is defined by the root unit.

## Timing
- **Reset values (on the edge with `rst` = 1):**
  - State IDLE, `ptr` = 0, `owner` = 0, counter = 0.
  - `sqrt_a` = 0, `resp_data` = 0, `resp_timeout` = 0.
  - `resp_valid` = 0, `req_ready` = 0 (forced 0 while `rst` is high), `busy` = 0, `sqrt_rst` = 1.
- **Reset mid-operation:** abandons any LOAD/RUN/DONE. The pending result is lost and is never delivered.
- **Latency**
  - Accept edge T puts the block in LOAD during T+1 and RUN from T+2.
  - If `sqrt_rdy` is first high in RUN cycle k (k = 1 is the first), `resp_valid` rises at T+2+k.
  - Timeout: `resp_valid` rises at T+2+TIMEOUT.
- **Throughput:** the DONE→IDLE handshake edge is followed by IDLE for at least 1 cycle. A new grant can occur in that first IDLE cycle.
- **Back-pressure:** while DONE is held by a low `resp_ready`, all `req_ready` stay 0 and outputs are stable.

## Structure
- Shared package `elmo_pe_pkg`: state encoding (2-bit: IDLE = 0, LOAD = 1, RUN = 2, DONE = 3) and the default `TIMEOUT` constant.
- Counter width is `$clog2(TIMEOUT)`.
- Sub-module `rr_pick #(N)`: combinational round-robin priority picker.
  - Inputs: `valid[N]`, `ptr`.
  - Outputs: one-hot `grant`, `idx`, `any`.
- The FSM, watchdog and registers live in the top module. The bench instantiates the real `squareroot_f32`, or a latency-programmable behavioural model of it.

## Test plan
- **Single request:** req 0, `a` = 0x40000000, model latency k = 13. Expect `resp_valid` = 0001 at T+15, `resp_data` = 0x3fb504f3, `resp_timeout` = 0, and `sqrt_rst` low exactly during RUN.
- **All four requesting at once:** operands 0x40000000, 0x40400000, 0x3f800000, 0x3fc00000. Expect grants in order 0,1,2,3 with results 0x3fb504f3, 0x3fddb3d7, 0x3f800000, 0x3f9cc471 routed to the matching `resp_valid` bit. Then re-request only 0 and 2: the next grant goes to 0 (`ptr` wrapped).
- **Response back-pressure:** hold `resp_ready[owner]` = 0 for 5 cycles in DONE. Expect `resp_valid`/`resp_data` stable, `req_ready` = 0 despite pending requests, and a grant one cycle after the handshake.
- **Watchdog:** model never raises `rdy`, `TIMEOUT` = 32. Expect `resp_valid` at T+34 with `resp_timeout` = 1. The next request then completes normally with `resp_timeout` = 0.
- **Rdy at the timeout boundary:** `rdy` first high in RUN cycle 32 with `TIMEOUT` = 32. Expect `resp_timeout` = 0 and `resp_data` = the model result.
- **Reset in RUN:** pulse `rst` high for 1 cycle at RUN cycle 5. Expect all outputs at reset values on the next cycle, `sqrt_rst` = 1, no `resp_valid` ever for that request, and `ptr` = 0: with all requesters valid, the next grant goes to requester 0.
